regfile_sweep: RTL

Parametrised self-checking sweep sequencer for the register file. On `start` it writes a deterministic pattern to every register via the write port, walking addresses up or down. It then reads every register back through both read ports and compares against the expected pattern. Sits between the board wrapper (keys/LEDs, divided clock) and the register file, replacing ad-hoc fixed-offset counters with a complete write/read-back check.

---
 rtl/regfile_sweep_pkg.sv | 29 ++
 rtl/regfile_sweep_if.sv | 23 ++
 rtl/regfile_sweep_counter.sv | 34 +++
 rtl/regfile_sweep.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/regfile_sweep_pkg.sv
// rtl/regfile_sweep_pkg.sv - shared types, direction constants and expected-value function for the sweep
package regfile_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_t;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Widest data path the expected-value helper handles; callers mask down to their width.
  localparam int MAX_DATA_W = 64;

  // Pattern written to address addr: base + addr, except the hardwired-zero register reads 0.
  function automatic logic [MAX_DATA_W-1:0] expected_value(
    input logic [MAX_DATA_W-1:0] base,
    input logic [31:0]           addr,
    input int                    zero_reg
  );
    if (zero_reg >= 0 && addr == $unsigned(zero_reg)) begin
      return '0;
    end
    return base + {32'd0, addr};
  endfunction

endpackage

// File: rtl/regfile_sweep_if.sv
// rtl/regfile_sweep_if.sv - register-file write/read port bundle between sweeper and register file
interface regfile_sweep_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr1;
  logic [ADDR_W-1:0] rd_addr2;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    input  rd_data1, rd_data2
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr1, rd_addr2,
    output rd_data1, rd_data2
  );
endinterface

// File: rtl/regfile_sweep_counter.sv
// rtl/regfile_sweep_counter.sv - bounded up/down sequence index with terminal-index flag
module sweep_counter
  import regfile_sweep_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              en,
  input  logic              dir,
  output logic [ADDR_W-1:0] idx,
  output logic              last
);
  localparam logic [ADDR_W-1:0] TOP = ADDR_W'(DEPTH - 1);

  // Load the start index for the direction, otherwise step and fold at the ends so idx stays in [0, DEPTH-1].
  always_ff @(posedge clk) begin
    if (reset) begin
      idx <= '0;
    end else if (load) begin
      idx <= (dir == DIR_DOWN) ? TOP : '0;
    end else if (en) begin
      if (dir == DIR_DOWN) begin
        idx <= (idx == '0) ? TOP : idx - 1'b1;
      end else begin
        idx <= (idx == TOP) ? '0 : idx + 1'b1;
      end
    end
  end

  assign last = (dir == DIR_DOWN) ? (idx == '0) : (idx == TOP);
endmodule

// File: rtl/regfile_sweep.sv
// rtl/regfile_sweep.sv - write-then-read-back sweep sequencer for the register file
module regfile_sweep
  import regfile_sweep_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = -1,
  parameter int ERR_W    = $clog2(2 * DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              dir,
  input  logic [DATA_W-1:0] base_data,
  regfile_sweep_if.master   rf,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] err_addr
);
  localparam logic [ADDR_W-1:0]     TOP       = ADDR_W'(DEPTH - 1);
  localparam logic [MAX_DATA_W-1:0] DATA_MASK = {MAX_DATA_W{1'b1}} >> (MAX_DATA_W - DATA_W);
  localparam int                    SUM_W     = ERR_W + 1;

  sweep_state_t      state_q, state_d;
  logic              dir_q;
  logic [DATA_W-1:0] base_q;
  logic              pass_q;
  logic [ERR_W-1:0]  err_count_q;
  logic [ADDR_W-1:0] err_addr_q;

  logic              cnt_load, cnt_en, cnt_dir, cnt_last;
  logic [ADDR_W-1:0] idx;

  logic                  in_write, in_read;
  logic [MAX_DATA_W-1:0] exp1, exp2;
  logic                  mm1, mm2;
  logic [SUM_W-1:0]      err_sum;
  logic [ERR_W-1:0]      err_next;

  // In IDLE the counter loads with the live dir; afterwards it follows the captured one.
  assign cnt_dir = (state_q == ST_IDLE) ? dir : dir_q;

  sweep_counter #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_counter (
    .clk   (clk),
    .reset (reset),
    .load  (cnt_load),
    .en    (cnt_en),
    .dir   (cnt_dir),
    .idx   (idx),
    .last  (cnt_last)
  );

  // Next state and counter control; the counter's last flag ends each phase.
  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_WRITE;
          cnt_load = 1'b1;
        end
      end
      ST_WRITE: begin
        if (cnt_last) begin
          state_d  = ST_READ;
          cnt_load = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_READ: begin
        if (cnt_last) begin
          state_d = ST_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; reset aborts any sweep on the edge it is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign in_write    = (state_q == ST_WRITE);
  assign in_read     = (state_q == ST_READ);
  assign rf.wr_en    = in_write;
  assign rf.wr_addr  = in_write ? idx : '0;
  assign rf.wr_data  = in_write ? base_q + DATA_W'(idx) : '0;
  assign rf.rd_addr1 = in_read ? idx : '0;
  assign rf.rd_addr2 = in_read ? TOP - idx : '0;
  assign busy        = in_write | in_read;
  assign done        = (state_q == ST_DONE);
  assign pass        = pass_q;
  assign err_count   = err_count_q;
  assign err_addr    = err_addr_q;

  // Compare both read ports against the pattern and form the saturating error increment.
  always_comb begin
    exp1     = expected_value(MAX_DATA_W'(base_q), 32'(rf.rd_addr1), ZERO_REG) & DATA_MASK;
    exp2     = expected_value(MAX_DATA_W'(base_q), 32'(rf.rd_addr2), ZERO_REG) & DATA_MASK;
    mm1      = in_read && (MAX_DATA_W'(rf.rd_data1) != exp1);
    mm2      = in_read && (MAX_DATA_W'(rf.rd_data2) != exp2);
    err_sum  = {1'b0, err_count_q} + SUM_W'(mm1) + SUM_W'(mm2);
    err_next = err_sum[ERR_W] ? '1 : err_sum[ERR_W-1:0];
  end

  // Capture sweep parameters on start, accumulate errors during READ, publish the verdict in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      dir_q       <= DIR_UP;
      base_q      <= '0;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else if (state_q == ST_IDLE && start) begin
      dir_q       <= dir;
      base_q      <= base_data;
      pass_q      <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else if (in_read) begin
      err_count_q <= err_next;
      if (err_count_q == '0) begin
        if (mm1) begin
          err_addr_q <= rf.rd_addr1;
        end else if (mm2) begin
          err_addr_q <= rf.rd_addr2;
        end
      end
    end else if (state_q == ST_DONE) begin
      pass_q <= (err_count_q == '0);
    end
  end
endmodule
